multi_initiator: RTL and testbench
==================================

Name: multi_initiator

Overview:
- Initiator (requester) end of the single-outstanding start/done multi-cycle transaction interface.
- Accepts requests on a valid/ready upstream port and issues each one to a responder with a one-cycle `start` pulse plus `data_in`.
- Waits for the responder's `done`, captures `data_out`, and returns the result and measured latency on a valid/ready response port.
- Provides a timeout for a missing `done` and a sticky flag for a spurious `done`.

Parameters:
- DATA_W, 32, width of request/response data (matches responder `data_in`/`data_out`).
- TIMEOUT, 64, cycles to wait for `done` before aborting; legal range 1..2^LAT_W-1.
- LAT_W, 8, width of the latency counter and `rsp_latency`.

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-low reset: 0 = in reset.
- req_valid, input, 1, upstream request present.
- req_ready, output, 1, request accepted when `req_valid & req_ready`.
- req_data, input, DATA_W, request payload.
- start, output, 1, one-cycle pulse to the responder.
- data_in, output, DATA_W, payload to the responder; valid while start is high.
- done, input, 1, responder completion strobe.
- data_out, input, DATA_W, responder result; sampled only when `done` is high.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, downstream accepts the response.
- rsp_data, output, DATA_W, captured `data_out`; 0 on timeout.
- rsp_latency, output, LAT_W, cycles from the start cycle to the done cycle; equals TIMEOUT on timeout.
- rsp_err, output, 1, 1 = timed out.
- spurious, output, 1, sticky; set by `done` outside WAIT; cleared only by reset.

Behaviour:
- Reset values (asynchronous on `reset`=0):
  - state = IDLE.
  - start = 0, data_in = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_latency = 0, rsp_err = 0.
  - spurious = 0, latency counter = 0.
- States: IDLE, ISSUE, WAIT, RESP. One transaction outstanding at most.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready).
- Request acceptance: on accept, register req_data into data_in and go to ISSUE.
- ISSUE:
  - start = 1 for exactly this cycle; lat = 0 during ISSUE.
  - Next state is WAIT; lat becomes 1 on entry.
- WAIT, checked in this priority order each cycle:
  - done=1: capture data_out into rsp_data, rsp_latency = lat, rsp_err = 0; go to RESP.
  - else lat==TIMEOUT: rsp_data = 0, rsp_latency = TIMEOUT, rsp_err = 1; go to RESP.
  - else lat = lat+1.
  - lat never exceeds TIMEOUT, so no wrap occurs.
- Latency definition: start at cycle t, done at cycle t+k gives rsp_latency = k (minimum 1).
- RESP:
  - rsp_valid = 1; rsp_* held stable until `rsp_valid & rsp_ready`.
  - On handshake: if req_valid, go directly to ISSUE with the new data (zero bubble); else go to IDLE.
- data_in holds its value from ISSUE until the next accepted request.
- done in IDLE, ISSUE or RESP (including a late done after a timeout): set spurious; data_out ignored; state unaffected.
- done in the same cycle that start is high: spurious.
- rsp_valid is registered; no combinational path from done or data_out to rsp_*.
- Reset mid-transaction: all outputs return to reset values immediately and the pending request is lost. The responder is not reset by this block; any trailing done after reset release sets spurious.

Test Plan:
1. Responder with internal delay 0 (done one cycle after start); req_data=0xDEADBEEF, rsp_ready=1 → start pulse of 1 cycle with data_in=0xDEADBEEF; rsp_valid with rsp_data=0xDEADBEEF, rsp_latency=1, rsp_err=0.
2. Three back-to-back requests 0x1, 0x2, 0x3 against a responder whose delay increments 0,1,2 → rsp_latency 1, 2, 3. start is re-issued in the cycle after each response handshake (no IDLE cycle).
3. Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 → req_ready=0 and rsp_* stable throughout; accept the next request on the cycle rsp_ready rises.
4. Timeout, TIMEOUT=4, no done → rsp_err=1, rsp_data=0, rsp_latency=4 at the 4th WAIT cycle. Then inject done in IDLE → spurious=1 and stays 1.
5. Assert reset=0 mid-WAIT → start, rsp_valid and spurious all 0 asynchronously. After release, a responder done sets spurious=1 and no response is produced.
6. done asserted in the ISSUE cycle → spurious=1; a later in-WAIT done completes normally.

Source files
------------

// File: rtl/multi_initiator.sv
// Initiator end of a single-outstanding start/done transaction link.
// It takes requests on a valid/ready port and pulses start with data_in.
// It waits for done, or gives up after TIMEOUT cycles.
// It returns the result and the measured latency on a valid/ready port.
// A done that arrives outside WAIT sets a sticky spurious flag.
module multi_initiator #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int LAT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              start,
  output logic [DATA_W-1:0] data_in,
  input  logic              done,
  input  logic [DATA_W-1:0] data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [LAT_W-1:0]  rsp_latency,
  output logic              rsp_err,
  output logic              spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [LAT_W-1:0] lat_reg, lat_next;
  logic             accept;

  // start and rsp_valid are pure decodes of the state register, so no path
  // exists from done or data_out to them.
  assign start     = (state_reg == ISSUE);
  assign rsp_valid = (state_reg == RESP);

  // Next-state, latency counter and request handshake decode.
  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    accept     = 1'b0;
    req_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          lat_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // The first WAIT cycle counts as latency 1.
        lat_next   = LAT_W'(1);
        state_next = WAIT;
      end
      WAIT: begin
        // done has priority over timeout in the same cycle.
        if (done) begin
          state_next = RESP;
        end else if (lat_reg == TIMEOUT_L) begin
          state_next = RESP;
        end else begin
          lat_next = lat_reg + LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          req_ready = 1'b1;
          // A waiting request goes straight to ISSUE, so no idle cycle occurs.
          if (req_valid) begin
            accept     = 1'b1;
            lat_next   = '0;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      lat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
    end
  end

  // The responder payload changes only when a new request is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_in <= '0;
    end else if (accept) begin
      data_in <= req_data;
    end
  end

  // Capture the response when WAIT ends; it holds stable through RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_data    <= '0;
      rsp_latency <= '0;
      rsp_err     <= 1'b0;
    end else if (state_reg == WAIT) begin
      if (done) begin
        rsp_data    <= data_out;
        rsp_latency <= lat_reg;
        rsp_err     <= 1'b0;
      end else if (lat_reg == TIMEOUT_L) begin
        rsp_data    <= '0;
        rsp_latency <= TIMEOUT_L;
        rsp_err     <= 1'b1;
      end
    end
  end

  // Sticky flag for a done outside WAIT.
  // This includes a late done after a timeout, and a done in the start cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      spurious <= 1'b0;
    end else if (done && (state_reg != WAIT)) begin
      spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_initiator.sv
// Testbench for multi_initiator. The responder is modelled inside the bench.
// Expected responses are queued when a request is driven.
// They are popped and compared on each response handshake.
module tb_multi_initiator;

  localparam int DW = 32;
  localparam int TO = 4;
  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid, req_ready, start, done, rsp_valid, rsp_ready;
  logic          rsp_err, spurious;
  logic [DW-1:0] req_data, data_in, data_out, rsp_data;
  logic [LW-1:0] rsp_latency;
  logic          resp_done = 1'b0;
  logic          man_done  = 1'b0;

  assign done = resp_done | man_done;

  always #5 clock = ~clock;

  multi_initiator #(.DATA_W(DW), .TIMEOUT(TO), .LAT_W(LW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .start(start), .data_in(data_in), .done(done), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_latency(rsp_latency), .rsp_err(rsp_err), .spurious(spurious)
  );

  typedef struct {
    logic [31:0] req;
    int          delay;
    logic        en;
    logic [31:0] xr;
    logic [31:0] edata;
    logic [7:0]  elat;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  l;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          errors = 0;
  int          checks = 0;

  // responder model state
  bit          r_en = 1'b1;
  bit          r_pend = 1'b0;
  int          r_cnt = 0;
  int          r_delay = 0;
  logic [31:0] r_xor = '0;
  logic [31:0] r_data = '0;
  bit          last_acc, last_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [7:0] l, input logic e);
    exp_t t;
    t.d = d;
    t.l = l;
    t.e = e;
    sb.push_back(t);
  endtask

  // One clock cycle. Handshakes and start are sampled before the edge.
  // Then the scoreboard and the responder act just after the edge.
  task automatic step();
    logic        hs, acc, st, se;
    logic [31:0] din, sd;
    logic [7:0]  sl;
    exp_t        e;
    #1;
    hs  = rsp_valid && rsp_ready;
    acc = req_valid && req_ready;
    st  = start;
    din = data_in;
    sd  = rsp_data;
    sl  = rsp_latency;
    se  = rsp_err;
    @(posedge clock);
    #1;
    last_acc = acc;
    last_hs  = hs;
    if (hs) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %0h, expected no response", sd);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", {32'd0, sd}, {32'd0, e.d});
        chk("rsp_latency", {56'd0, sl}, {56'd0, e.l});
        chk("rsp_err", {63'd0, se}, {63'd0, e.e});
      end
    end
    resp_done = 1'b0;
    if (st && r_en) begin
      r_cnt  = r_delay;
      r_pend = 1'b1;
      r_data = din ^ r_xor;
    end
    if (r_pend) begin
      if (r_cnt == 0) begin
        resp_done = 1'b1;
        data_out  = r_data;
        r_pend    = 1'b0;
      end else begin
        r_cnt--;
      end
    end
  endtask

  task automatic wait_acc();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = last_acc;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: no accept seen, expected one within 20 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    req_valid = 1'b0;
    req_data  = '0;
    rsp_ready = 1'b1;
    data_out  = '0;

    // Vector table: req, delay, responder enable, xor, exp data, exp latency, exp err
    vecs[0] = '{32'hDEADBEEF, 0, 1'b1, 32'h00000000, 32'hDEADBEEF, 8'd1, 1'b0};
    vecs[1] = '{32'h12345678, 1, 1'b1, 32'hFFFF0000, 32'hEDCB5678, 8'd2, 1'b0};
    vecs[2] = '{32'h000000FF, 3, 1'b1, 32'h0F0F0F0F, 32'h0F0F0FF0, 8'd4, 1'b0};
    vecs[3] = '{32'hA5A5A5A5, 2, 1'b1, 32'hFFFFFFFF, 32'h5A5A5A5A, 8'd3, 1'b0};
    vecs[4] = '{32'hCAFEF00D, 0, 1'b0, 32'h00000000, 32'h00000000, 8'd4, 1'b1};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_start", {63'd0, start}, 64'd0);
    chk("rst_data_in", {32'd0, data_in}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_rsp_latency", {56'd0, rsp_latency}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_spurious", {63'd0, spurious}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    reset = 1'b1;
    step();

    // Single transactions from the table. The timeout case is last.
    for (int i = 0; i < 5; i++) begin
      r_delay   = vecs[i].delay;
      r_xor     = vecs[i].xr;
      r_en      = vecs[i].en;
      req_data  = vecs[i].req;
      req_valid = 1'b1;
      push_exp(vecs[i].edata, vecs[i].elat, vecs[i].eerr);
      wait_acc();
      req_valid = 1'b0;
      chk("start_pulse", {63'd0, start}, 64'd1);
      chk("data_in", {32'd0, data_in}, {32'd0, vecs[i].req});
      step();
      chk("start_end", {63'd0, start}, 64'd0);
      wait_drain();
      chk("idle_after_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("no_spurious", {63'd0, spurious}, 64'd0);
      $display("vec %0d: req=%0h delay=%0d err=%0b", i, vecs[i].req, vecs[i].delay, vecs[i].eerr);
    end

    // Back-to-back requests with responder delays 0, 1 and 2
    r_en  = 1'b1;
    r_xor = '0;
    push_exp(32'h1, 8'd1, 1'b0);
    push_exp(32'h2, 8'd2, 1'b0);
    push_exp(32'h3, 8'd3, 1'b0);
    r_delay   = 0;
    req_data  = 32'h1;
    req_valid = 1'b1;
    wait_acc();
    step();
    for (int k = 2; k <= 3; k++) begin
      r_delay  = k - 1;
      req_data = 32'(k);
      wait_acc();
      chk("b2b_zero_bubble", {63'd0, last_hs}, 64'd1);
      chk("b2b_start", {63'd0, start}, 64'd1);
      chk("b2b_data_in", {32'd0, data_in}, 64'(k));
      step();
    end
    req_valid = 1'b0;
    wait_drain();
    $display("b2b: three requests done");

    // Backpressure on the response port
    r_delay   = 0;
    r_xor     = 32'h11111111;
    rsp_ready = 1'b0;
    req_data  = 32'h600D0000;
    req_valid = 1'b1;
    push_exp(32'h711C1111, 8'd1, 1'b0);
    wait_acc();
    req_valid = 1'b0;
    wait_valid();
    req_data  = 32'hBEEF0001;
    req_valid = 1'b1;
    push_exp(32'hAFFE1110, 8'd1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_rsp_data", {32'd0, rsp_data}, 64'h711C1111);
      chk("bp_rsp_latency", {56'd0, rsp_latency}, 64'd1);
    end
    rsp_ready = 1'b1;
    wait_acc();
    chk("bp_release_hs", {63'd0, last_hs}, 64'd1);
    chk("bp_release_start", {63'd0, start}, 64'd1);
    chk("bp_release_data_in", {32'd0, data_in}, 64'hBEEF0001);
    req_valid = 1'b0;
    wait_drain();
    $display("backpressure: done");

    // A done while IDLE sets the sticky spurious flag
    chk("pre_spurious", {63'd0, spurious}, 64'd0);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    chk("idle_done_spurious", {63'd0, spurious}, 64'd1);
    repeat (3) step();
    chk("spurious_sticky", {63'd0, spurious}, 64'd1);
    chk("idle_done_no_rsp", {63'd0, rsp_valid}, 64'd0);
    $display("idle done: spurious=%0b", spurious);

    // Reset asserted in the middle of WAIT
    r_delay   = 6;
    r_xor     = '0;
    req_data  = 32'h55;
    req_valid = 1'b1;
    push_exp(32'h55, 8'd7, 1'b0);
    wait_acc();
    req_valid = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("arst_start", {63'd0, start}, 64'd0);
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst_spurious", {63'd0, spurious}, 64'd0);
    chk("arst_data_in", {32'd0, data_in}, 64'd0);
    sb.delete();
    step();
    reset = 1'b1;
    repeat (10) step();
    chk("trailing_done_spurious", {63'd0, spurious}, 64'd1);
    chk("trailing_no_rsp", {63'd0, rsp_valid}, 64'd0);
    $display("mid-wait reset: spurious=%0b", spurious);

    // A done in the ISSUE cycle is spurious; the in-WAIT done still completes
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("reset_clears_spurious", {63'd0, spurious}, 64'd0);
    r_delay   = 1;
    r_xor     = 32'h0000FFFF;
    req_data  = 32'h12340000;
    req_valid = 1'b1;
    push_exp(32'h1234FFFF, 8'd2, 1'b0);
    wait_acc();
    req_valid = 1'b0;
    man_done  = 1'b1;
    step();
    man_done  = 1'b0;
    chk("issue_done_spurious", {63'd0, spurious}, 64'd1);
    wait_drain();
    $display("issue-cycle done: spurious=%0b", spurious);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
